// File: rtl/jtkcpu_pkg.sv
// Shared JTKCPU definitions: addressing-mode encodings and EA sequencer states.
package jtkcpu_pkg;

  typedef enum logic [3:0] {
    EA_ZERO   = 4'd0,
    EA_OFS8   = 4'd1,
    EA_OFS16  = 4'd2,
    EA_ACC    = 4'd3,
    EA_INC1   = 4'd4,
    EA_INC2   = 4'd5,
    EA_DEC1   = 4'd6,
    EA_DEC2   = 4'd7,
    EA_DIRECT = 4'd8,
    EA_EXT    = 4'd9
  } ea_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_IND_HI,
    ST_IND_LO,
    ST_DONE
  } ea_state_e;

endpackage

// File: rtl/jtkcpu_ea_calc.sv
// Combinational effective-address mux/adder; also yields the index writeback value.
module jtkcpu_ea_calc
  import jtkcpu_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [3:0]    mode,
  input  logic [AW-1:0] idx_reg,
  input  logic [AW-1:0] racc,
  input  logic [15:0]   ofs,
  input  logic [7:0]    dp,
  output logic [AW-1:0] ea,
  output logic [AW-1:0] wb_data,
  output logic          wb_en
);

  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] TWO = AW'(2);

  always_comb begin
    ea      = idx_reg;
    wb_data = idx_reg;
    wb_en   = 1'b0;
    case (mode)
      EA_ZERO:   ea = idx_reg;
      EA_OFS8:   ea = idx_reg + AW'($signed(ofs[7:0]));
      EA_OFS16:  ea = idx_reg + AW'(ofs);
      EA_ACC:    ea = idx_reg + racc;
      EA_INC1: begin
        wb_data = idx_reg + ONE;
        wb_en   = 1'b1;
      end
      EA_INC2: begin
        wb_data = idx_reg + TWO;
        wb_en   = 1'b1;
      end
      EA_DEC1: begin
        ea      = idx_reg - ONE;
        wb_data = idx_reg - ONE;
        wb_en   = 1'b1;
      end
      EA_DEC2: begin
        ea      = idx_reg - TWO;
        wb_data = idx_reg - TWO;
        wb_en   = 1'b1;
      end
      EA_DIRECT: ea = AW'({dp, ofs[7:0]});
      EA_EXT:    ea = AW'(ofs);
      default:   ea = idx_reg;
    endcase
  end

endmodule

// File: rtl/jtkcpu_ea.sv
// JTKCPU effective-address unit: latches operands, registers the EA, and
// optionally follows a big-endian pointer through the bus-read handshake.
module jtkcpu_ea
  import jtkcpu_pkg::*;
#(
  parameter int AW       = 16,
  parameter int BUSW     = 8,
  parameter int INDIRECT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            start,
  input  logic [3:0]      mode,
  input  logic            ind,
  input  logic [AW-1:0]   idx_reg,
  input  logic [AW-1:0]   racc,
  input  logic [15:0]     ofs,
  input  logic [7:0]      dp,
  output logic            rd_req,
  output logic [AW-1:0]   rd_addr,
  input  logic [BUSW-1:0] rd_data,
  input  logic            rd_ack,
  output logic [AW-1:0]   addr,
  output logic            busy,
  output logic            done,
  output logic            reg_we,
  output logic [AW-1:0]   reg_wdata
);

  ea_state_e     state_q, state_d;
  logic [3:0]    mode_q, mode_d;
  logic          ind_q, ind_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] racc_q, racc_d;
  logic [15:0]   ofs_q, ofs_d;
  logic [7:0]    dp_q, dp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    msb_q, msb_d;

  logic [AW-1:0] ea;
  logic [AW-1:0] wb_data;
  logic          wb_en;

  jtkcpu_ea_calc #(.AW(AW)) u_calc (
    .mode    (mode_q),
    .idx_reg (idx_q),
    .racc    (racc_q),
    .ofs     (ofs_q),
    .dp      (dp_q),
    .ea      (ea),
    .wb_data (wb_data),
    .wb_en   (wb_en)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ind_d   = ind_q;
    idx_d   = idx_q;
    racc_d  = racc_q;
    ofs_d   = ofs_q;
    dp_d    = dp_q;
    addr_d  = addr_q;
    msb_d   = msb_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          ind_d   = ind;
          idx_d   = idx_reg;
          racc_d  = racc;
          ofs_d   = ofs;
          dp_d    = dp;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        addr_d  = ea;
        state_d = (ind_q && (INDIRECT != 0)) ? ST_IND_HI : ST_DONE;
      end
      ST_IND_HI: begin
        if (rd_ack) begin
          if (BUSW == 16) begin
            addr_d  = AW'(rd_data);
            state_d = ST_DONE;
          end else begin
            msb_d   = rd_data[7:0];
            state_d = ST_IND_LO;
          end
        end
      end
      ST_IND_LO: begin
        if (rd_ack) begin
          addr_d  = AW'({msb_q, rd_data[7:0]});
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_req    = (state_q == ST_IND_HI) || (state_q == ST_IND_LO);
    rd_addr   = '0;
    if (state_q == ST_IND_HI) rd_addr = addr_q;
    if (state_q == ST_IND_LO) rd_addr = addr_q + AW'(1);
    addr      = addr_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    reg_we    = (state_q == ST_CALC) && wb_en;
    reg_wdata = wb_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      ind_q   <= 1'b0;
      idx_q   <= '0;
      racc_q  <= '0;
      ofs_q   <= '0;
      dp_q    <= '0;
      addr_q  <= '0;
      msb_q   <= '0;
    end else if (cen) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ind_q   <= ind_d;
      idx_q   <= idx_d;
      racc_q  <= racc_d;
      ofs_q   <= ofs_d;
      dp_q    <= dp_d;
      addr_q  <= addr_d;
      msb_q   <= msb_d;
    end
  end

endmodule

// File: tb/tb_jtkcpu_ea.sv
// Directed bench for jtkcpu_ea: mode table on an 8-bit-bus instance plus
// hand-written indirect, cen-freeze and reset sequences; one 16-bit-bus instance.
module tb_jtkcpu_ea;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        start, start16;
  logic [3:0]  mode;
  logic        ind;
  logic [15:0] idx_reg, racc, ofs;
  logic [7:0]  dp;

  logic [7:0]  rd_data8;
  logic        rd_ack8;
  logic        rd_req8, busy8, done8, reg_we8;
  logic [15:0] rd_addr8, addr8, reg_wdata8;

  logic [15:0] rd_data16;
  logic        rd_ack16;
  logic        rd_req16, busy16, done16, reg_we16;
  logic [15:0] rd_addr16, addr16, reg_wdata16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jtkcpu_ea #(.AW(16), .BUSW(8), .INDIRECT(1)) dut8 (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .mode(mode), .ind(ind),
    .idx_reg(idx_reg), .racc(racc), .ofs(ofs), .dp(dp),
    .rd_req(rd_req8), .rd_addr(rd_addr8), .rd_data(rd_data8), .rd_ack(rd_ack8),
    .addr(addr8), .busy(busy8), .done(done8), .reg_we(reg_we8), .reg_wdata(reg_wdata8)
  );

  jtkcpu_ea #(.AW(16), .BUSW(16), .INDIRECT(1)) dut16 (
    .clk(clk), .rst(rst), .cen(cen), .start(start16), .mode(mode), .ind(ind),
    .idx_reg(idx_reg), .racc(racc), .ofs(ofs), .dp(dp),
    .rd_req(rd_req16), .rd_addr(rd_addr16), .rd_data(rd_data16), .rd_ack(rd_ack16),
    .addr(addr16), .busy(busy16), .done(done16), .reg_we(reg_we16), .reg_wdata(reg_wdata16)
  );

  typedef struct {
    logic [3:0]  mode;
    logic [15:0] idx;
    logic [15:0] racc;
    logic [15:0] ofs;
    logic [7:0]  dp;
    logic [15:0] exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    mode = v.mode; idx_reg = v.idx; racc = v.racc; ofs = v.ofs; dp = v.dp;
    ind = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check($sformatf("%s calc_busy", tag), busy8, 1);
    check($sformatf("%s calc_we", tag), reg_we8, v.exp_we);
    if (v.exp_we) check($sformatf("%s calc_wdata", tag), reg_wdata8, v.exp_wdata);
    check($sformatf("%s calc_done", tag), done8, 0);
    @(negedge clk);
    check($sformatf("%s done", tag), done8, 1);
    check($sformatf("%s addr", tag), addr8, v.exp_addr);
    check($sformatf("%s done_we", tag), reg_we8, 0);
    @(negedge clk);
    check($sformatf("%s done_drop", tag), done8, 0);
    check($sformatf("%s idle", tag), busy8, 0);
    check($sformatf("%s addr_hold", tag), addr8, v.exp_addr);
  endtask

  task automatic start_ind(input logic [3:0] m, input logic [15:0] idx);
    mode = m; idx_reg = idx; racc = 16'h0; ofs = 16'h0; dp = 8'h0;
    ind = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; ind = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  16'h1234, 16'h0000, 16'h0000, 8'h00, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{4'd1,  16'h1000, 16'h0000, 16'h00F0, 8'h00, 16'h0FF0, 1'b0, 16'h0000};
    vecs[2]  = '{4'd1,  16'h1000, 16'h0000, 16'hFF7F, 8'h00, 16'h107F, 1'b0, 16'h0000};
    vecs[3]  = '{4'd2,  16'hF000, 16'h0000, 16'h2000, 8'h00, 16'h1000, 1'b0, 16'h0000};
    vecs[4]  = '{4'd3,  16'h4000, 16'hFFFE, 16'h0000, 8'h00, 16'h3FFE, 1'b0, 16'h0000};
    vecs[5]  = '{4'd4,  16'h00FF, 16'h0000, 16'h0000, 8'h00, 16'h00FF, 1'b1, 16'h0100};
    vecs[6]  = '{4'd5,  16'hFFFF, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 1'b1, 16'h0001};
    vecs[7]  = '{4'd6,  16'h2000, 16'h0000, 16'h0000, 8'h00, 16'h1FFF, 1'b1, 16'h1FFF};
    vecs[8]  = '{4'd7,  16'h0001, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[9]  = '{4'd8,  16'h7777, 16'h0000, 16'h0034, 8'h12, 16'h1234, 1'b0, 16'h0000};
    vecs[10] = '{4'd8,  16'h7777, 16'h0000, 16'hAB34, 8'h12, 16'h1234, 1'b0, 16'h0000};
    vecs[11] = '{4'd9,  16'h7777, 16'h0000, 16'hBEEF, 8'h00, 16'hBEEF, 1'b0, 16'h0000};
    vecs[12] = '{4'd12, 16'h5555, 16'h0000, 16'h00FF, 8'h00, 16'h5555, 1'b0, 16'h0000};

    rst = 1'b1; cen = 1'b1; start = 1'b0; start16 = 1'b0; mode = 4'd0; ind = 1'b0;
    idx_reg = '0; racc = '0; ofs = '0; dp = '0;
    rd_data8 = '0; rd_ack8 = 1'b0; rd_data16 = '0; rd_ack16 = 1'b0;
    #1;
    check("rst addr", addr8, 0);
    check("rst rd_req", rd_req8, 0);
    check("rst rd_addr", rd_addr8, 0);
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst reg_we", reg_we8, 0);
    check("rst reg_wdata", reg_wdata8, 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Indirect through 8-bit bus, pointer straddles FFFF->0000, 3-cycle ack delay
    mode = 4'd9; ofs = 16'hFFFF; idx_reg = 16'h0; ind = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; ind = 1'b0;
    check("ind8 calc_we", reg_we8, 0);
    @(negedge clk);
    check("ind8 hi_req", rd_req8, 1);
    check("ind8 hi_addr", rd_addr8, 16'hFFFF);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check("ind8 hi_wait_req", rd_req8, 1);
      check("ind8 hi_wait_done", done8, 0);
    end
    rd_data8 = 8'hAB; rd_ack8 = 1'b1;
    @(negedge clk); rd_ack8 = 1'b0;
    check("ind8 lo_req", rd_req8, 1);
    check("ind8 lo_addr", rd_addr8, 16'h0000);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      check("ind8 lo_wait_addr", rd_addr8, 16'h0000);
      check("ind8 lo_wait_done", done8, 0);
    end
    rd_data8 = 8'hCD; rd_ack8 = 1'b1;
    @(negedge clk); rd_ack8 = 1'b0;
    check("ind8 done", done8, 1);
    check("ind8 addr", addr8, 16'hABCD);
    check("ind8 req_drop", rd_req8, 0);
    @(negedge clk);
    check("ind8 done_single", done8, 0);
    check("ind8 idle", busy8, 0);

    // Indirect through 16-bit bus: single beat
    mode = 4'd3; idx_reg = 16'h4000; racc = 16'h0010; ofs = 16'h0; ind = 1'b1; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0; ind = 1'b0;
    check("ind16 calc_busy", busy16, 1);
    @(negedge clk);
    check("ind16 req", rd_req16, 1);
    check("ind16 rd_addr", rd_addr16, 16'h4010);
    rd_data16 = 16'h5678; rd_ack16 = 1'b1;
    @(negedge clk); rd_ack16 = 1'b0;
    check("ind16 done", done16, 1);
    check("ind16 addr", addr16, 16'h5678);
    check("ind16 req_drop", rd_req16, 0);
    @(negedge clk);
    check("ind16 done_single", done16, 0);
    check("ind16 idle", busy16, 0);

    // start during IND_HI ignored; writeback issued before the long fetch
    start_ind(4'd4, 16'h3000);
    check("rob_a calc_we", reg_we8, 1);
    check("rob_a calc_wdata", reg_wdata8, 16'h3001);
    @(negedge clk);
    mode = 4'd9; ofs = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rob_a still_req", rd_req8, 1);
    check("rob_a rd_addr", rd_addr8, 16'h3000);
    check("rob_a no_we", reg_we8, 0);
    rd_data8 = 8'h12; rd_ack8 = 1'b1;
    @(negedge clk); rd_ack8 = 1'b0;
    check("rob_a lo_addr", rd_addr8, 16'h3001);
    rd_data8 = 8'h34; rd_ack8 = 1'b1;
    @(negedge clk); rd_ack8 = 1'b0;
    check("rob_a done", done8, 1);
    check("rob_a addr", addr8, 16'h1234);
    @(negedge clk);
    check("rob_a idle", busy8, 0);

    // cen low for 5 cycles inside IND_LO, with rd_ack held high meanwhile
    start_ind(4'd0, 16'h3000);
    @(negedge clk);
    rd_data8 = 8'h56; rd_ack8 = 1'b1;
    @(negedge clk);
    cen = 1'b0; rd_data8 = 8'h99;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      check("rob_b frz_req", rd_req8, 1);
      check("rob_b frz_addr", rd_addr8, 16'h3001);
      check("rob_b frz_done", done8, 0);
    end
    cen = 1'b1; rd_data8 = 8'h78;
    @(negedge clk); rd_ack8 = 1'b0;
    check("rob_b done", done8, 1);
    check("rob_b addr", addr8, 16'h5678);
    cen = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("rob_b done_stretch", done8, 1);
    end
    cen = 1'b1;
    @(negedge clk);
    check("rob_b done_drop", done8, 0);
    check("rob_b idle", busy8, 0);

    // Asynchronous reset in IND_LO, then a fresh operation
    start_ind(4'd0, 16'h3000);
    @(negedge clk);
    rd_data8 = 8'h11; rd_ack8 = 1'b1;
    @(negedge clk); rd_ack8 = 1'b0;
    check("rob_c lo_req", rd_req8, 1);
    rst = 1'b1;
    #1;
    check("rob_c rst_req", rd_req8, 0);
    check("rob_c rst_busy", busy8, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[7], "rob_c fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
